// File: rtl/freq_input_gate_if.sv
// freq_input_gate_if
//   Signal bundle between the frequency-meter front end and its neighbours.
//   slave  : the gate block (samples signal_in/enable, drives the rest)
//   master : whoever drives the pin/enable and consumes the strobes
//   signal_in    raw measured signal, asynchronous to the system clock
//   enable       measurement enable level, synchronous to the system clock
//   signal_clean synchronised, glitch-filtered level
//   edge_pulse   one-cycle strobe per accepted rising edge inside the gate
//   gate_open    gate window active
//   gate_start   first cycle of a window (counter clear)
//   gate_done    cycle after a window completed normally (counter latch)
//   gate_abort   window cut short by enable dropping
interface freq_input_gate_if;
    logic signal_in;
    logic enable;
    logic signal_clean;
    logic edge_pulse;
    logic gate_open;
    logic gate_start;
    logic gate_done;
    logic gate_abort;

    modport master (
        output signal_in, enable,
        input  signal_clean, edge_pulse, gate_open, gate_start, gate_done, gate_abort
    );

    modport slave (
        input  signal_in, enable,
        output signal_clean, edge_pulse, gate_open, gate_start, gate_done, gate_abort
    );
endinterface

// File: rtl/freq_input_gate.sv
// freq_input_gate
//   Front end of the frequency meter. Synchronises the raw input pin, rejects
//   pulses shorter than FILTER_LEN cycles, strobes on accepted rising edges,
//   and generates the gate window (GATE_CYCLES open + one latch cycle) that
//   the downstream edge counter uses to clear, count and latch.
//   Ports:
//     clk  system clock, rising edge
//     rst  asynchronous active-high reset
//     bus  freq_input_gate_if.slave (signal_in/enable in, strobes/levels out)
//   Parameters:
//     GATE_CYCLES  clock cycles per gate window (>= 2)
//     FILTER_LEN   cycles a new level must persist before acceptance (>= 1)
//     SYNC_STAGES  synchroniser depth (>= 2)
module freq_input_gate #(
    parameter int GATE_CYCLES = 50_000_000,
    parameter int FILTER_LEN  = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    freq_input_gate_if.slave  bus
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int GW = $clog2(GATE_CYCLES);
    localparam logic [FW-1:0] F_LAST = FW'(FILTER_LEN - 1);
    localparam logic [GW-1:0] G_LAST = GW'(GATE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OPEN = 2'd1,
        DONE = 2'd2
    } state_t;

    // ---------------------------------------------------------------
    // Input conditioning: synchroniser, persistence filter, rise detect
    // ---------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   sync;
    logic [FW-1:0]          fcnt;
    logic                   clean_r;
    logic                   clean_d;
    logic                   rise_r;

    assign sync = sync_ff[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_ff <= '0;
            fcnt    <= '0;
            clean_r <= 1'b0;
            clean_d <= 1'b0;
            rise_r  <= 1'b0;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], bus.signal_in};
            // A disagreeing level must hold for FILTER_LEN consecutive
            // samples; any return to the accepted level restarts the count.
            if (sync != clean_r) begin
                if (fcnt == F_LAST) begin
                    clean_r <= sync;
                    fcnt    <= '0;
                end else begin
                    fcnt <= fcnt + 1'b1;
                end
            end else begin
                fcnt <= '0;
            end
            // Strobe lands in the cycle after the filtered level rises,
            // so the counter sees one fixed latency from pin to strobe.
            clean_d <= clean_r;
            rise_r  <= clean_r & ~clean_d;
        end
    end

    // ---------------------------------------------------------------
    // Gate window FSM, all outputs registered
    // ---------------------------------------------------------------
    state_t        state;
    logic [GW-1:0] gcnt;
    logic          open_r;
    logic          start_r;
    logic          done_r;
    logic          abort_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            gcnt    <= '0;
            open_r  <= 1'b0;
            start_r <= 1'b0;
            done_r  <= 1'b0;
            abort_r <= 1'b0;
        end else begin
            start_r <= 1'b0;
            done_r  <= 1'b0;
            abort_r <= 1'b0;
            case (state)
                IDLE: begin
                    open_r <= 1'b0;
                    if (bus.enable) begin
                        state   <= OPEN;
                        gcnt    <= '0;
                        open_r  <= 1'b1;
                        start_r <= 1'b1;
                    end
                end
                OPEN: begin
                    // Abort is checked first so a drop on the last open
                    // cycle never yields a (partial) latch strobe.
                    if (!bus.enable) begin
                        state   <= IDLE;
                        open_r  <= 1'b0;
                        abort_r <= 1'b1;
                    end else if (gcnt == G_LAST) begin
                        state  <= DONE;
                        open_r <= 1'b0;
                        done_r <= 1'b1;
                    end else begin
                        gcnt <= gcnt + 1'b1;
                    end
                end
                DONE: begin
                    // Single latch cycle, then straight into the next window.
                    if (bus.enable) begin
                        state   <= OPEN;
                        gcnt    <= '0;
                        open_r  <= 1'b1;
                        start_r <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    open_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.signal_clean = clean_r;
    assign bus.edge_pulse   = rise_r & open_r;
    assign bus.gate_open    = open_r;
    assign bus.gate_start   = start_r;
    assign bus.gate_done    = done_r;
    assign bus.gate_abort   = abort_r;

endmodule

// File: tb/tb_freq_input_gate.sv
// tb_freq_input_gate
//   Self-checking bench for freq_input_gate with GATE_CYCLES=10,
//   FILTER_LEN=3, SYNC_STAGES=2. Expected output bits are queued by cycle
//   number when stimulus is driven and compared on the falling clock edge.
//   Output vector order: {signal_clean, edge_pulse, gate_open, gate_start,
//   gate_done, gate_abort}.
module tb_freq_input_gate;
    localparam int GC = 10;

    localparam logic [5:0] M_CLEAN = 6'b100000;
    localparam logic [5:0] M_EDGE  = 6'b010000;
    localparam logic [5:0] M_OPEN  = 6'b001000;
    localparam logic [5:0] M_START = 6'b000100;
    localparam logic [5:0] M_DONE  = 6'b000010;
    localparam logic [5:0] M_ABORT = 6'b000001;
    localparam logic [5:0] M_ALL   = 6'b111111;
    localparam logic [5:0] M_GATE  = 6'b011111;

    typedef struct {
        string      name;
        int         at;
        logic [5:0] mask;
        logic [5:0] exp;
    } sb_t;

    typedef struct {
        string      name;
        logic       en;
        logic [5:0] exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    int         cyc   = 0;
    int         tests = 0;
    int         fails = 0;
    sb_t        sb[$];
    sb_t        mon_e;
    logic [5:0] dout;

    freq_input_gate_if bus();

    assign dout = {bus.signal_clean, bus.edge_pulse, bus.gate_open,
                   bus.gate_start, bus.gate_done, bus.gate_abort};

    freq_input_gate #(
        .GATE_CYCLES(GC),
        .FILTER_LEN (3),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int at, input logic [5:0] mask,
                         input logic [5:0] act, input logic [5:0] exp);
        tests++;
        if ((act & mask) !== (exp & mask)) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%b want=%b mask=%b",
                     name, at, act & mask, exp & mask, mask);
        end
    endtask

    function automatic void sb_push(input string name, input int at,
                                    input logic [5:0] mask, input logic [5:0] exp);
        sb_t e;
        int  i;
        e.name = name;
        e.at   = at;
        e.mask = mask;
        e.exp  = exp;
        i = sb.size();
        while (i > 0 && sb[i-1].at > at) i--;
        sb.insert(i, e);
    endfunction

    // Scoreboard: compare every entry due in this cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            mon_e = sb.pop_front();
            if (mon_e.at < cyc) begin
                tests++;
                fails++;
                $display("FAIL %s got=unchecked_at_%0d want=cyc_%0d", mon_e.name, cyc, mon_e.at);
            end else begin
                check(mon_e.name, mon_e.at, mon_e.mask, dout, mon_e.exp);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb.size() > 0; i++) @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            mon_e = sb.pop_front();
            tests++;
            fails++;
            $display("FAIL %s got=timeout want=cyc_%0d", mon_e.name, mon_e.at);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=time_%0t want=finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t cad[37];
        int   c, k, d0, a;

        // Cadence table: row i drives enable before edge i+1 and gives the
        // expected outputs in cycle n=i+1. Window = 10 open + 1 done.
        for (int i = 0; i < 37; i++) begin
            int n, m;
            n = i + 1;
            m = (n - 1) % 11;
            cad[i].name = $sformatf("cad%0d", n);
            cad[i].en   = (i < 35);
            cad[i].exp  = {1'b0, 1'b0, (n <= 35 && m < 10), (n <= 35 && m == 0),
                           (n <= 35 && m == 10), (n == 36)};
        end

        // Reset state
        rst = 1'b1;
        bus.signal_in = 1'b0;
        bus.enable    = 1'b0;
        tick(3);
        check("reset_state", cyc, M_ALL, dout, 6'b000000);
        rst = 1'b0;
        tick(3);

        // Gate cadence, enable high 35 cycles then low
        foreach (cad[i]) begin
            bus.enable = cad[i].en;
            sb_push(cad[i].name, cyc + 1, M_ALL, cad[i].exp);
            tick(1);
        end
        drain();
        tick(3);

        // Latency: rising input -> clean after k+4, edge_pulse at k+5 only
        bus.enable = 1'b1;
        tick(1);
        k = cyc + 1;
        sb_push("lat_clean_pre", k + 3, M_CLEAN | M_EDGE, 6'b000000);
        sb_push("lat_clean",     k + 4, M_CLEAN | M_EDGE, 6'b100000);
        sb_push("lat_edge",      k + 5, M_CLEAN | M_EDGE | M_OPEN, 6'b111000);
        sb_push("lat_edge_end",  k + 6, M_EDGE, 6'b000000);
        bus.signal_in = 1'b1;
        tick(7);
        // Falling edge: level follows, no strobe
        k = cyc + 1;
        sb_push("fall_pre",  k + 3, M_CLEAN | M_EDGE, 6'b100000);
        sb_push("fall",      k + 4, M_CLEAN | M_EDGE, 6'b000000);
        sb_push("fall_ne1",  k + 5, M_EDGE | M_OPEN, 6'b001000);
        sb_push("fall_ne2",  k + 6, M_EDGE | M_OPEN, 6'b001000);
        bus.signal_in = 1'b0;
        tick(7);
        bus.enable = 1'b0;
        sb_push("lat_abort", cyc + 1, M_OPEN | M_DONE | M_ABORT, 6'b000001);
        drain();
        tick(3);

        // Glitch: 2-cycle pulse rejected, 3-cycle pulse gives one strobe
        bus.enable = 1'b1;
        tick(1);
        k = cyc + 1;
        for (int j = 0; j < 8; j++) sb_push("glitch2", k + j, M_CLEAN | M_EDGE, 6'b000000);
        bus.signal_in = 1'b1;
        tick(2);
        bus.signal_in = 1'b0;
        tick(8);
        k = cyc + 1;
        for (int j = 0; j < 10; j++)
            sb_push("pulse3", k + j, M_CLEAN | M_EDGE,
                    {(j >= 4 && j <= 6), (j == 5), 4'b0000});
        bus.signal_in = 1'b1;
        tick(3);
        bus.signal_in = 1'b0;
        tick(10);
        bus.enable = 1'b0;
        drain();
        tick(3);

        // Counting: period-8 input; one strobe inside the window, the rise
        // landing in the DONE cycle must be suppressed
        d0 = 0;
        for (int i = 0; i < 26; i++) begin
            bus.signal_in = (((i + 3) % 8) < 4);
            if (i == 8) begin
                bus.enable = 1'b1;
                d0 = cyc;
                for (int j = 1; j <= 14; j++)
                    sb_push($sformatf("count%0d", j), d0 + j, M_GATE,
                            {1'b0, (j == 3), (j <= 10), (j == 1), (j == 11), 1'b0});
            end
            if (i == 19) bus.enable = 1'b0;
            tick(1);
        end
        drain();
        tick(3);

        // Abort in the 10th open cycle, then a fresh full window
        bus.enable = 1'b1;
        a = cyc;
        sb_push("abort_open10", a + 10, M_OPEN | M_DONE | M_ABORT, 6'b001000);
        sb_push("abort_pulse",  a + 11, M_GATE, 6'b000001);
        sb_push("abort_idle",   a + 12, M_GATE, 6'b000000);
        sb_push("abort_nodone", a + 13, M_GATE, 6'b000000);
        tick(10);
        bus.enable = 1'b0;
        tick(4);
        bus.enable = 1'b1;
        a = cyc;
        sb_push("re_start",  a + 1,  M_OPEN | M_START | M_DONE, 6'b001100);
        sb_push("re_open2",  a + 2,  M_OPEN | M_START, 6'b001000);
        sb_push("re_open10", a + 10, M_OPEN | M_DONE, 6'b001000);
        sb_push("re_done",   a + 11, M_OPEN | M_DONE | M_ABORT, 6'b000010);
        tick(11);
        bus.enable = 1'b0;
        drain();
        tick(3);

        // Asynchronous reset mid-window while an edge strobe is live
        bus.signal_in = 1'b1;
        bus.enable    = 1'b1;
        c = cyc;
        sb_push("pre_rst", c + 5, M_CLEAN | M_OPEN | M_DONE, 6'b101000);
        tick(6);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async", cyc, M_ALL, dout, 6'b000000);
        for (int j = 0; j < 4; j++) begin
            bus.signal_in = ~bus.signal_in;
            tick(1);
            #2;
            check("rst_hold", cyc, M_ALL, dout, 6'b000000);
        end
        bus.enable    = 1'b0;
        bus.signal_in = 1'b0;
        rst = 1'b0;
        for (int j = 1; j <= 8; j++) sb_push("post_rst", cyc + j, M_ALL, 6'b000000);
        tick(9);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
